// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths, FSM encoding and segment constants for fib_run_ctrl
package fib_pkg;
   localparam int N_WIDTH_DEF     = 8;
   localparam int RES_WIDTH_DEF   = 16;
   localparam int TIMEOUT_CYC_DEF = 4096;
   localparam int SCAN_BITS_DEF   = 17;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t START = 2'd1;
   localparam state_t WAIT  = 2'd2;

   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_E    = 7'b0000110;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - nibble to active-low seven-segment decoder, seg = {g,f,e,d,c,b,a}
module hex7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/fib_run_ctrl.sv
// rtl/fib_run_ctrl.sv - run controller for the fib core with multiplexed hex display
// Optional macro FIB_CYCLE_CNT_EN adds the last_cycles run-length output.
module fib_run_ctrl
   import fib_pkg::*;
#(
   parameter int N_WIDTH     = N_WIDTH_DEF,
   parameter int RES_WIDTH   = RES_WIDTH_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int SCAN_BITS   = SCAN_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_WIDTH-1:0]   sw,
   output logic                 core_start,
   output logic [N_WIDTH-1:0]   core_n,
   input  logic                 core_done,
   input  logic [RES_WIDTH-1:0] core_result,
   output logic [RES_WIDTH-1:0] result,
   output logic                 result_valid,
   output logic                 busy,
   output logic                 error,
`ifdef FIB_CYCLE_CNT_EN
   output logic [15:0]          last_cycles,
`endif
   output logic [3:0]           an,
   output logic [6:0]           seg
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYC - 1);

   logic [N_WIDTH-1:0]   sw_m;
   logic [N_WIDTH-1:0]   sw_s;
   logic [1:0]           sync_fill;
   state_t               state;
   logic                 pending;
   logic [TW-1:0]        tcnt;
   logic [SCAN_BITS-1:0] scan;
   logic [1:0]           digit;
   logic [3:0]           nibble;
   logic [6:0]           hex_seg;

   assign core_start = (state == START);

   // sync_fill keeps IDLE from acting on the zeros the synchronizer holds just after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_m         <= '0;
         sw_s         <= '0;
         sync_fill    <= 2'b00;
         state        <= IDLE;
         pending      <= 1'b1;
         tcnt         <= '0;
         core_n       <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
      end else begin
         sw_m      <= sw;
         sw_s      <= sw_m;
         sync_fill <= {sync_fill[0], 1'b1};
         case (state)
            IDLE: begin
               if (sync_fill[1] && (pending || sw_s != core_n)) begin
                  core_n       <= sw_s;
                  pending      <= 1'b0;
                  result_valid <= 1'b0;
                  busy         <= 1'b1;
                  state        <= START;
               end
            end
            START: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (core_done) begin
                  result       <= core_result;
                  result_valid <= 1'b1;
                  error        <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else if (tcnt == T_LIM) begin
                  error        <= 1'b1;
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef FIB_CYCLE_CNT_EN
   logic [15:0] cyc;

   // cyc holds the count of the current cycle; the START cycle is count 1
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc         <= 16'd0;
         last_cycles <= 16'd0;
      end else if (state == START) begin
         cyc <= 16'd2;
      end else if (state == WAIT) begin
         if (core_done) last_cycles <= cyc;
         else           cyc         <= sat_inc16(cyc);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) scan <= '0;
      else       scan <= scan + SCAN_BITS'(1);
   end

   assign digit = scan[SCAN_BITS-1 -: 2];
   assign an    = ~(4'b0001 << digit);

   always_comb begin
      nibble = result[3:0];
      case (digit)
         2'd1: nibble = result[7:4];
         2'd2: nibble = result[11:8];
         2'd3: nibble = result[15:12];
         default: nibble = result[3:0];
      endcase
   end

   hex7seg u_hex7seg (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_comb begin
      seg = hex_seg;
      if (error)                      seg = SEG_E;
      else if (busy && !result_valid) seg = SEG_DASH;
   end
endmodule

// File: tb/tb_fib_run_ctrl.sv
// tb/tb_fib_run_ctrl.sv - self-checking bench for fib_run_ctrl with a delayed-response core model
module tb_fib_run_ctrl;
   localparam int TO = 16;
   localparam logic [6:0] S_DASH = 7'b0111111;
   localparam logic [6:0] S_E    = 7'b0000110;
   localparam logic [31:0] RST_VEC = {1'b0, 8'd0, 16'd0, 3'b000, 4'b1110};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  sw = 8'd0;
   logic        core_start;
   logic [7:0]  core_n;
   logic        core_done = 1'b0;
   logic [15:0] core_result = 16'd0;
   logic [15:0] result;
   logic        result_valid;
   logic        busy;
   logic        error;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;
   int core_delay = 5;
   bit core_mute = 1'b0;
   logic [7:0] model_n = 8'd0;

   fib_run_ctrl #(.N_WIDTH(8), .RES_WIDTH(16), .TIMEOUT_CYC(TO), .SCAN_BITS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .sw           (sw),
      .core_start   (core_start),
      .core_n       (core_n),
      .core_done    (core_done),
      .core_result  (core_result),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .error        (error),
      .an           (an),
      .seg          (seg)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fib(input int n);
      int a, b, t;
      a = 0;
      b = 1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return 16'(a);
   endfunction

   // Core model: answers fib(n) core_delay cycles after the start pulse
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (core_start === 1'b1) begin
            start_cnt++;
            model_n = core_n;
            cd = core_delay;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0 && !core_mute) begin
               core_done = 1'b1;
               core_result = fib(int'(model_n));
            end
         end
      end
   end

   task automatic wait_start(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (core_start !== 1'b1 && k < 200);
      checks++;
      if (core_start !== 1'b1) begin
         failures++;
         $display("FAIL %s_start_wait got=timeout required=core_start", name);
      end
   endtask

   task automatic wait_busy_low(input string name);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy_wait got=timeout required=busy_low", name);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sw = 8'd2;
      core_delay = 5;
      repeat (3) @(negedge clk);
      start_cnt = 0;
      checks++;
      if ({core_start, core_n, result, result_valid, busy, error, an} !== RST_VEC) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=%h",
                  {core_start, core_n, result, result_valid, busy, error, an}, RST_VEC);
      end
      checks++;
      if (seg !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_seg got=%b required=1000000", seg);
      end
   endtask

   task automatic test_basic();
      reset = 1'b0;
      wait_start("basic");
      wait_busy_low("basic");
      repeat (10) @(negedge clk);
      checks++;
      if (start_cnt != 1) begin
         failures++;
         $display("FAIL basic_start_count got=%0d required=1", start_cnt);
      end
      checks++;
      if ({core_n, result, result_valid, busy, error} !== {8'd2, fib(2), 3'b100}) begin
         failures++;
         $display("FAIL basic_result got n=%0d res=%h v=%b b=%b e=%b required n=2 res=%h v=1 b=0 e=0",
                  core_n, result, result_valid, busy, error, fib(2));
      end
   endtask

   task automatic test_sequence();
      sw = 8'd4;
      wait_start("seq4");
      wait_busy_low("seq4");
      checks++;
      if (result !== fib(4)) begin
         failures++;
         $display("FAIL seq_n4 got=%h required=%h", result, fib(4));
      end
      repeat (30) @(negedge clk);
      sw = 8'd7;
      wait_start("seq7");
      wait_busy_low("seq7");
      checks++;
      if (result !== fib(7) || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL seq_n7 got=%h v=%b required=%h v=1", result, result_valid, fib(7));
      end
   endtask

   task automatic test_display();
      logic [3:0] seen;
      logic [6:0] exp_seg;
      int d;
      seen = 4'b0000;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         d = 0;
         for (int b = 0; b < 4; b++) if (an[b] === 1'b0) d = b;
         seen[d] = 1'b1;
         checks++;
         if ($countones(an) != 3) begin
            failures++;
            $display("FAIL disp_an_onehot got=%b required=one_low_bit", an);
         end
         exp_seg = (d == 0) ? 7'b0100001 : 7'b1000000;
         checks++;
         if (seg !== exp_seg) begin
            failures++;
            $display("FAIL disp_seg_digit%0d got=%b required=%b", d, seg, exp_seg);
         end
      end
      checks++;
      if (seen !== 4'b1111) begin
         failures++;
         $display("FAIL disp_scan_cover got=%b required=1111", seen);
      end
   endtask

   task automatic test_mid_change();
      core_delay = 8;
      sw = 8'd2;
      wait_start("mid");
      repeat (2) @(negedge clk);
      sw = 8'd7;
      checks++;
      if (seg !== S_DASH) begin
         failures++;
         $display("FAIL mid_dash got=%b required=%b", seg, S_DASH);
      end
      wait_busy_low("mid");
      checks++;
      if (result !== fib(2) || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_first_result got=%h v=%b required=%h v=1", result, result_valid, fib(2));
      end
      @(negedge clk);
      checks++;
      if (core_start !== 1'b1 || core_n !== 8'd7) begin
         failures++;
         $display("FAIL mid_restart got start=%b n=%0d required start=1 n=7", core_start, core_n);
      end
      wait_busy_low("mid2");
      checks++;
      if (result !== fib(7)) begin
         failures++;
         $display("FAIL mid_final got=%h required=%h", result, fib(7));
      end
   endtask

   task automatic test_timeout();
      int s0;
      logic [15:0] prev;
      prev = fib(7);
      core_mute = 1'b1;
      sw = 8'd5;
      wait_start("tmo");
      for (int i = 1; i <= TO; i++) begin
         @(negedge clk);
         checks++;
         if (error !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early cycle=%0d got=%b required=0", i, error);
         end
      end
      @(negedge clk);
      checks++;
      if ({error, busy, result_valid, result} !== {3'b100, prev}) begin
         failures++;
         $display("FAIL tmo_abort got e=%b b=%b v=%b res=%h required e=1 b=0 v=0 res=%h",
                  error, busy, result_valid, result, prev);
      end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         checks++;
         if (seg !== S_E) begin
            failures++;
            $display("FAIL tmo_seg got=%b required=%b", seg, S_E);
         end
      end
      s0 = start_cnt;
      repeat (40) @(negedge clk);
      checks++;
      if (start_cnt != s0) begin
         failures++;
         $display("FAIL tmo_no_retry got=%0d required=%0d", start_cnt, s0);
      end
      core_mute = 1'b0;
   endtask

   task automatic test_coincident();
      core_delay = TO;
      sw = 8'd9;
      wait_start("coin");
      wait_busy_low("coin");
      checks++;
      if ({error, result_valid, result} !== {2'b01, fib(9)}) begin
         failures++;
         $display("FAIL coin_done_wins got e=%b v=%b res=%h required e=0 v=1 res=%h",
                  error, result_valid, result, fib(9));
      end
   endtask

   task automatic test_reset_mid();
      core_delay = 4;
      sw = 8'd11;
      wait_start("rmid");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({core_start, core_n, result, result_valid, busy, error, an} !== RST_VEC) begin
         failures++;
         $display("FAIL rmid_outputs got=%h required=%h",
                  {core_start, core_n, result, result_valid, busy, error, an}, RST_VEC);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (result !== 16'd0 || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_done_dropped got res=%h v=%b required res=0000 v=0", result, result_valid);
      end
      wait_start("rmid_restart");
      wait_busy_low("rmid_restart");
      checks++;
      if (core_n !== 8'd11 || result !== fib(11) || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL rmid_restart got n=%0d res=%h v=%b required n=11 res=%h v=1",
                  core_n, result, result_valid, fib(11));
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_res;
      logic        exp_err;
      logic [7:0]  n;
      int          dly;
      exp_res = fib(11);
      for (int it = 0; it < 10; it++) begin
         do n = 8'($urandom_range(0, 24)); while (n == sw);
         dly = int'($urandom_range(1, TO + 2));
         core_delay = dly;
         sw = n;
         wait_start("rand");
         wait_busy_low("rand");
         repeat (3) @(negedge clk);
         exp_err = (dly > TO);
         if (!exp_err) exp_res = fib(int'(n));
         checks++;
         if ({error, result_valid, result} !== {exp_err, ~exp_err, exp_res}) begin
            failures++;
            $display("FAIL rand_run n=%0d delay=%0d got e=%b v=%b res=%h required e=%b v=%b res=%h",
                     n, dly, error, result_valid, result, exp_err, ~exp_err, exp_res);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sequence();
      test_display();
      test_mid_change();
      test_timeout();
      test_coincident();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
